// File: rtl/dc2421_monitor.sv
// dc2421_monitor: receiving-end checker for a 2421-coded decade counter.
// Decodes each sampled 2421 word to BCD, flags illegal words and sequence
// breaks, tracks lock to a counting sequence and counts 9->0 roll-overs in BCD.
module dc2421_monitor #(
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] code,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] wraps
);

  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {StHunt, StTrack, StLocked} state_e;

  state_e            state_q, state_d;
  logic [3:0]        ref_q, ref_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        digit_q, digit_d;
  logic              dv_q, dv_d;
  logic              ill_q, ill_d;
  logic              seq_q, seq_d;
  logic [7:0]        wraps_q, wraps_d;

  logic              legal;
  logic [3:0]        dec;
  logic [3:0]        expect_dig;
  logic              match;
  logic [CntW-1:0]   cnt_inc;
  logic [7:0]        wraps_inc;

  // 2421 -> 8421 decode; the six middle words are not part of the code
  always_comb begin
    legal = 1'b1;
    dec   = 4'd0;
    unique case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: dec = code;
      4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111: dec = code - 4'd6;
      default: legal = 1'b0;
    endcase
  end

  // Expected successor, lock-counter increment and BCD roll-over increment
  always_comb begin
    expect_dig = (ref_q == 4'd9) ? 4'd0 : ref_q + 4'd1;
    match      = (dec == expect_dig);
    cnt_inc    = cnt_q + CntW'(1);
    wraps_inc  = wraps_q;
    if (wraps_q[3:0] == 4'd9) begin
      wraps_inc[3:0] = 4'd0;
      wraps_inc[7:4] = (wraps_q[7:4] == 4'd9) ? 4'd0 : wraps_q[7:4] + 4'd1;
    end else begin
      wraps_inc[3:0] = wraps_q[3:0] + 4'd1;
    end
  end

  // Next-state: hunt/track/locked sequencing and pulse generation
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    wraps_d = wraps_q;
    dv_d    = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        ill_d   = 1'b1;
        state_d = StHunt;
      end else begin
        dv_d    = 1'b1;
        digit_d = dec;
        ref_d   = dec;
        unique case (state_q)
          StHunt: begin
            cnt_d   = '0;
            state_d = StTrack;
          end
          StTrack: begin
            if (match) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CntW'(LOCK_COUNT)) state_d = StLocked;
              if (ref_q == 4'd9) wraps_d = wraps_inc;
            end else begin
              seq_d = 1'b1;
              cnt_d = '0;
            end
          end
          StLocked: begin
            if (match) begin
              if (ref_q == 4'd9) wraps_d = wraps_inc;
            end else begin
              seq_d   = 1'b1;
              cnt_d   = '0;
              state_d = StTrack;
            end
          end
          default: state_d = StHunt;
        endcase
      end
    end
  end

  // State and output registers; reset wins over a same-edge sample
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHunt;
      ref_q   <= 4'd0;
      cnt_q   <= '0;
      digit_q <= 4'd0;
      dv_q    <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      wraps_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      wraps_q <= wraps_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign illegal     = ill_q;
  assign seq_err     = seq_q;
  assign locked      = (state_q == StLocked);
  assign wraps       = wraps_q;

endmodule

// File: tb/tb_dc2421_monitor.sv
// Bench for dc2421_monitor: a behavioural model pushes expected outputs into a
// scoreboard queue on every driven cycle; a checker pops and compares after
// the clock edge. Directed constant checks cover the key scenarios.
module tb_dc2421_monitor;

  localparam int unsigned LC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] code = 4'd0;
  logic [3:0] digit;
  logic       digit_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] wraps;

  dc2421_monitor #(.LOCK_COUNT(LC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .code        (code),
    .digit       (digit),
    .digit_valid (digit_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .wraps       (wraps)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] digit;
    logic       dv;
    logic       ill;
    logic       seq;
    logic       lk;
    logic [7:0] wraps;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  // Model state: 0 hunt, 1 track, 2 locked; wrap count kept as plain decimal
  int m_state, m_ref, m_cnt, m_digit, m_wraps;
  int cur;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int dec2421(input logic [3:0] c);
    case (c)
      4'h0: return 0;
      4'h1: return 1;
      4'h2: return 2;
      4'h3: return 3;
      4'h4: return 4;
      4'hb: return 5;
      4'hc: return 6;
      4'hd: return 7;
      4'he: return 8;
      4'hf: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] enc2421(input int d);
    case (d)
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h3;
      4: return 4'h4;
      5: return 4'hb;
      6: return 4'hc;
      7: return 4'hd;
      8: return 4'he;
      default: return 4'hf;
    endcase
  endfunction

  // Drive one cycle, advance the model, queue its expectation, then sit
  // just past the edge (after the scoreboard checker) for directed checks.
  task automatic step(input logic v, input logic [3:0] c, input logic rst);
    exp_t x;
    int   d;
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    code     = c;
    x.dv = 1'b0; x.ill = 1'b0; x.seq = 1'b0;
    if (rst) begin
      m_state = 0; m_ref = 0; m_cnt = 0; m_digit = 0; m_wraps = 0;
    end else if (v) begin
      d = dec2421(c);
      if (d < 0) begin
        x.ill   = 1'b1;
        m_state = 0;
      end else begin
        x.dv    = 1'b1;
        m_digit = d;
        if (m_state == 0) begin
          m_state = 1;
          m_cnt   = 0;
        end else if (d == (m_ref + 1) % 10) begin
          if (m_ref == 9) m_wraps = (m_wraps + 1) % 100;
          if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == LC) m_state = 2;
          end
        end else begin
          x.seq   = 1'b1;
          m_cnt   = 0;
          m_state = 1;
        end
        m_ref = d;
      end
    end
    x.digit = 4'(m_digit);
    x.lk    = (m_state == 2);
    x.wraps = {4'(m_wraps / 10), 4'(m_wraps % 10)};
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input int d);
    step(1'b1, enc2421(d), 1'b0);
    cur = d;
  endtask

  // Scoreboard checker: compare every queued expectation after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_digit", {4'h0, digit}, {4'h0, e.digit});
      chk("sb_dv", {7'h0, digit_valid}, {7'h0, e.dv});
      chk("sb_illegal", {7'h0, illegal}, {7'h0, e.ill});
      chk("sb_seq_err", {7'h0, seq_err}, {7'h0, e.seq});
      chk("sb_locked", {7'h0, locked}, {7'h0, e.lk});
      chk("sb_wraps", wraps, e.wraps);
    end
  end

  initial begin
    m_state = 0; m_ref = 0; m_cnt = 0; m_digit = 0; m_wraps = 0; cur = 0;
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h5, 1'b1);
    chk("rst_digit", {4'h0, digit}, 8'h00);
    chk("rst_locked", {7'h0, locked}, 8'h00);
    chk("rst_wraps", wraps, 8'h00);

    // Lock-up on 0,1,2,3
    for (int d = 0; d < 4; d++) begin
      feed(d);
      chk("lockup_digit", {4'h0, digit}, 8'(d));
      chk("lockup_locked", {7'h0, locked}, (d == 3) ? 8'h01 : 8'h00);
    end

    // First decade roll-over
    for (int d = 4; d < 10; d++) feed(d);
    feed(0);
    chk("wrap_first", wraps, 8'h01);
    chk("wrap_locked", {7'h0, locked}, 8'h01);

    // 100 more decades: pass 99 and roll to 00
    for (int i = 0; i < 100; i++) begin
      for (int d = 1; d < 10; d++) feed(d);
      feed(0);
      if (i == 97) chk("wrap_99", wraps, 8'h99);
      if (i == 98) chk("wrap_00", wraps, 8'h00);
    end

    // Illegal word while locked at 4
    for (int d = 1; d < 5; d++) feed(d);
    step(1'b1, 4'h7, 1'b0);
    chk("ill_pulse", {7'h0, illegal}, 8'h01);
    chk("ill_no_dv", {7'h0, digit_valid}, 8'h00);
    chk("ill_digit", {4'h0, digit}, 8'h04);
    chk("ill_locked", {7'h0, locked}, 8'h00);
    feed(5);
    chk("hunt_digit", {4'h0, digit}, 8'h05);
    chk("hunt_no_seq", {7'h0, seq_err}, 8'h00);

    // Relock, then skip and repeat from 4
    for (int d = 6; d < 10; d++) feed(d);
    for (int d = 0; d < 5; d++) feed(d);
    chk("relock", {7'h0, locked}, 8'h01);
    feed(6);
    chk("skip_seq", {7'h0, seq_err}, 8'h01);
    chk("skip_digit", {4'h0, digit}, 8'h06);
    chk("skip_locked", {7'h0, locked}, 8'h00);
    feed(6);
    chk("repeat_seq", {7'h0, seq_err}, 8'h01);
    feed(7);
    feed(8);
    chk("pre_lock", {7'h0, locked}, 8'h00);
    feed(9);
    chk("skip_relock", {7'h0, locked}, 8'h01);

    // Gaps between samples
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'h6, 1'b0);
      step(1'b0, 4'h9, 1'b0);
      chk("gap_dv", {7'h0, digit_valid}, 8'h00);
      chk("gap_locked", {7'h0, locked}, 8'h01);
      feed((cur + 1) % 10);
    end

    // Advance to wraps = 07, then reset with a sample present
    while (m_wraps != 7) feed((cur + 1) % 10);
    chk("pre_rst_wraps", wraps, 8'h07);
    step(1'b1, enc2421((cur + 1) % 10), 1'b1);
    chk("mid_rst_wraps", wraps, 8'h00);
    chk("mid_rst_locked", {7'h0, locked}, 8'h00);
    chk("mid_rst_digit", {4'h0, digit}, 8'h00);
    chk("mid_rst_dv", {7'h0, digit_valid}, 8'h00);
    feed(3);
    feed(5);
    step(1'b0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
